melody_sequencer: RTL and testbench

//  Upstream stage of the buzzer tone generator. Steps through a fixed melody table at a programmable tempo.
//  Per note, presents the tone generator's half-period cycle count plus a tone enable.

---
 rtl/melody_sequencer_if.sv | 22 ++
 rtl/melody_sequencer.sv | 135 +++++++++++++
 tb/tb_melody_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the play switch side and the melody sequencer.
// The master drives play/loop; the slave (sequencer) drives note and status outputs.
interface melody_sequencer_if;
  logic        play;
  logic        loop;
  logic [31:0] half_period;
  logic        tone_en;
  logic        note_strobe;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;

  modport master (
    output play, loop,
    input  half_period, tone_en, note_strobe, step_idx, busy, done
  );

  modport slave (
    input  play, loop,
    output half_period, tone_en, note_strobe, step_idx, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps an 8-entry melody table at BEAT_CYCLES per beat, presenting half-period and tone enable.
// Optional ARTIC_GAP_EN macro: silences the last GAP_CYCLES of every note (articulation gap).
module melody_sequencer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BEAT_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic               mclk,
  input  logic               rst,
  melody_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

  localparam logic [31:0] HP_C4 = 32'(CLK_HZ / (2 * 262));
  localparam logic [31:0] HP_D4 = 32'(CLK_HZ / (2 * 294));
  localparam logic [31:0] HP_E4 = 32'(CLK_HZ / (2 * 330));
  localparam logic [31:0] HP_F4 = 32'(CLK_HZ / (2 * 349));
  localparam logic [31:0] HP_G4 = 32'(CLK_HZ / (2 * 392));
  localparam logic [31:0] LEN_1 = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] LEN_2 = 32'(2 * BEAT_CYCLES - 1);

  if (BEAT_CYCLES <= GAP_CYCLES) begin : g_bad_cfg
    $error("melody_sequencer: BEAT_CYCLES must exceed GAP_CYCLES");
  end

  function automatic logic [31:0] f_hp(input logic [2:0] s);
    case (s)
      3'd0:    f_hp = HP_D4;
      3'd1:    f_hp = HP_E4;
      3'd2:    f_hp = HP_F4;
      3'd3:    f_hp = HP_G4;
      3'd4:    f_hp = HP_E4;
      3'd5:    f_hp = HP_C4;
      3'd6:    f_hp = HP_D4;
      default: f_hp = 32'd0;
    endcase
  endfunction

  // Counter reload value: beats*BEAT_CYCLES-1 so the step lasts exactly beats*BEAT_CYCLES cycles.
  function automatic logic [31:0] f_len(input logic [2:0] s);
    f_len = (s == 3'd4 || s == 3'd7) ? LEN_2 : LEN_1;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_step,  w_step_nxt;
  logic [31:0] r_dur,   w_dur_nxt;
  logic        w_strobe_nxt;
  logic        w_sounding;
  logic [31:0] w_hp_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_dur_nxt    = r_dur;
    w_strobe_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.play) begin
          w_state_nxt  = S_PLAY;
          w_step_nxt   = 3'd0;
          w_dur_nxt    = f_len(3'd0);
          w_strobe_nxt = 1'b1;
        end
      end
      S_PLAY, S_GAP: begin
        if (!bus.play) begin
          w_state_nxt = S_IDLE;
          w_step_nxt  = 3'd0;
          w_dur_nxt   = 32'd0;
        end else if (r_dur == 32'd0) begin
          if (r_step != 3'd7) begin
            w_state_nxt  = S_PLAY;
            w_step_nxt   = r_step + 3'd1;
            w_dur_nxt    = f_len(r_step + 3'd1);
            w_strobe_nxt = 1'b1;
          end else if (bus.loop) begin
            w_state_nxt  = S_PLAY;
            w_step_nxt   = 3'd0;
            w_dur_nxt    = f_len(3'd0);
            w_strobe_nxt = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_dur_nxt   = 32'd0;
          end
        end else begin
          w_dur_nxt = r_dur - 32'd1;
`ifdef ARTIC_GAP_EN
          // Enter GAP so that the counter reads GAP_CYCLES-1 on the first silent cycle.
          if (r_state == S_PLAY && r_dur == 32'(GAP_CYCLES))
            w_state_nxt = S_GAP;
`endif
        end
      end
      S_DONE: begin
        if (!bus.play) begin
          w_state_nxt = S_IDLE;
          w_step_nxt  = 3'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = 3'd0;
        w_dur_nxt   = 32'd0;
      end
    endcase
  end

  assign w_sounding = (w_state_nxt == S_PLAY) || (w_state_nxt == S_GAP);
  assign w_hp_nxt   = w_sounding ? f_hp(w_step_nxt) : 32'd0;

  // Outputs are registered from next-state values so they are valid on the step's first cycle.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_step          <= 3'd0;
      r_dur           <= 32'd0;
      bus.half_period <= 32'd0;
      bus.tone_en     <= 1'b0;
      bus.note_strobe <= 1'b0;
      bus.step_idx    <= 3'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_step          <= w_step_nxt;
      r_dur           <= w_dur_nxt;
      bus.half_period <= w_hp_nxt;
      bus.tone_en     <= (w_state_nxt == S_PLAY) && (w_hp_nxt != 32'd0);
      bus.note_strobe <= w_strobe_nxt;
      bus.step_idx    <= w_step_nxt;
      bus.busy        <= w_sounding;
      bus.done        <= (w_state_nxt == S_DONE);
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer; reference model tracks the position within a run
// and derives step, tone and strobe from the melody table by plain arithmetic.
module tb_melody_sequencer;
  localparam int CLK_HZ = 50_000_000;
  localparam int BEAT   = 8;
  localparam int GAP    = 2;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  melody_sequencer_if bus();

  melody_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Melody table as given: beats and half-period per step (REST = 0).
  int beats [8] = '{1, 1, 1, 1, 2, 1, 1, 2};
  int hps   [8] = '{85034, 75757, 71633, 63775, 75757, 95419, 85034, 0};

  // Model: mode 0 idle, 1 running, 2 done; pos = cycles since start of current pass.
  int m_mode = 0;
  int m_pos  = 0;

  function automatic int total_len();
    int t = 0;
    for (int i = 0; i < 8; i++) t += beats[i] * BEAT;
    return t;
  endfunction

  // Vector layout: {half_period[38:7], tone_en[6], note_strobe[5], step_idx[4:2], busy[1], done[0]}
  function automatic logic [38:0] obs_vec();
    return {bus.half_period, bus.tone_en, bus.note_strobe, bus.step_idx, bus.busy, bus.done};
  endfunction

  function automatic logic [38:0] exp_vec();
    int s, off, len;
    logic tone;
    if (m_mode == 1) begin
      s = 0;
      off = m_pos;
      while (s < 7 && off >= beats[s] * BEAT) begin
        off -= beats[s] * BEAT;
        s++;
      end
      len = beats[s] * BEAT;
`ifdef ARTIC_GAP_EN
      tone = (hps[s] != 0) && (off < len - GAP);
`else
      tone = (hps[s] != 0) && (len > 0);
`endif
      return {32'(hps[s]), tone, (off == 0), 3'(s), 1'b1, 1'b0};
    end else if (m_mode == 2) begin
      return {32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    end
    return 39'd0;
  endfunction

  // step_idx is not defined while finished, so it is ignored there.
  function automatic logic [38:0] msk();
    return (m_mode == 2) ? ~39'h1C : {39{1'b1}};
  endfunction

  task automatic cycle(input logic p, input logic l, input logic r);
    bus.play = p;
    bus.loop = l;
    rst      = r;
    @(posedge mclk);
    if (r) m_mode = 0;
    else begin
      case (m_mode)
        0: if (p) begin m_mode = 1; m_pos = 0; end
        1: begin
          if (!p) m_mode = 0;
          else if (m_pos + 1 == total_len()) begin
            if (l) m_pos = 0; else m_mode = 2;
          end else m_pos++;
        end
        default: if (!p) m_mode = 0;
      endcase
    end
    @(negedge mclk);
  endtask

  task automatic test_reset();
    logic [38:0] first;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== 39'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h want=0", i, obs_vec());
      end
    end
    cycle(1'b1, 1'b0, 1'b0);
    first = {32'd85034, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    checks++;
    if (obs_vec() !== first) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs_vec(), first);
    end
  endtask

  task automatic test_sequence();
    int n = 0;
    while (!bus.done && n < 200) begin
      cycle(1'b1, 1'b0, 1'b0);
      n++;
      checks++;
      if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
        errors++;
        $display("FAIL seq n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
    end
    // 10 beats of 8 cycles each from the first note cycle to DONE.
    checks++;
    if (n !== 10 * BEAT) begin
      errors++;
      $display("FAIL seq_len got=%0d want=%0d", n, 10 * BEAT);
    end
  endtask

  task automatic test_done_hold();
    logic [38:0] first;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if ((obs_vec() & msk()) !== (exp_vec() & msk()) || bus.done !== 1'b1) begin
        errors++;
        $display("FAIL done_hold cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 39'd0) begin
      errors++;
      $display("FAIL done_release got=%h want=0", obs_vec());
    end
    cycle(1'b1, 1'b0, 1'b0);
    first = {32'd85034, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    checks++;
    if (obs_vec() !== first) begin
      errors++;
      $display("FAIL done_replay got=%h want=%h", obs_vec(), first);
    end
  endtask

  task automatic test_loop();
    for (int i = 0; i < 2 * 10 * BEAT + 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL loop i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_abort();
    logic [38:0] first;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    // Advance to cycle 3 of step 2 (position 19), then drop play.
    for (int i = 0; i < 2 * BEAT + 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL abort_run i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.step_idx !== 3'd2) begin
      errors++;
      $display("FAIL abort_pre_step got=%0d want=2", bus.step_idx);
    end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 39'd0) begin
      errors++;
      $display("FAIL abort got=%h want=0", obs_vec());
    end
    cycle(1'b1, 1'b0, 1'b0);
    first = {32'd85034, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    checks++;
    if (obs_vec() !== first) begin
      errors++;
      $display("FAIL abort_restart got=%h want=%h", obs_vec(), first);
    end
  endtask

  task automatic test_random();
    logic p = 1'b1;
    logic l, r;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) p = ~p;
      l = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 499) == 0);
      cycle(p, l, r);
      checks++;
      if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
        errors++;
        $display("FAIL random i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.play = 1'b0;
    bus.loop = 1'b0;
    test_reset();
    test_sequence();
    test_done_hold();
    test_loop();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
